// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU type definitions.
//   regbits_t : register-number field of an instruction (5 bits).
//   hzst_t    : state of the pipeline hazard controller FSM.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  // Hazard controller states.
  //   RUN      : normal issue, per-cycle hazard resolution
  //   MEM_WAIT : data access outstanding, whole pipeline frozen
  //   DRAIN    : one-cycle flush after a halt reaches EX/MEM
  //   HALTED   : pipeline drained, left only through reset
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hzst_t;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: pure combinational load-use hazard compare.
// Flags when the instruction in EX is a load whose destination register
// is a source of the instruction in ID.
//   idex_dMemREN  : EX instruction is a load
//   idex_writeReg : destination register of the EX instruction
//   ifid_rs       : rs field of the ID instruction
//   ifid_rt       : rt field of the ID instruction
//   ifid_uses_rt  : ID instruction actually reads rt
//   load_use      : hazard present
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dMemREN,
  input  regbits_t idex_writeReg,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_uses_rt,
  output logic     load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_writeReg == ifid_rs);
  assign rt_match = ifid_uses_rt && (idex_writeReg == ifid_rt);

  // $zero is never a real dependency, so a load into r0 never stalls.
  assign load_use = idex_dMemREN && (idex_writeReg != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller of the five-stage pipeline.
// Drives writeEN/flush of the IF/ID, ID/EX, EX/MEM latches, writeEN of MEM/WB
// and pc_en, from fetch/data handshakes, load-use, EX redirects and halt.
//
// Latch-control handshake: a latch loads its input on a rising edge when its
// writeEN=1; when flush=1 together with writeEN=1 it loads a bubble instead.
// writeEN=0 holds the latch regardless of flush.
//
// Ports:
//   CLK, nRST                    : clock, asynchronous active-low reset
//   ihit, dhit                   : fetch / data access complete this cycle
//   ifid_rs, ifid_rt,
//   ifid_uses_rt                 : source operands of the ID instruction
//   idex_dMemREN, idex_writeReg  : load flag / destination of EX instruction
//   exmem_dMemREN, exmem_dMemWEN : memory op in EX/MEM
//   exmem_Halt                   : halt in EX/MEM
//   ex_redirect                  : taken branch / jump resolved in EX
//   pc_en, *_writeEN, *_flush    : latch controls (combinational)
//   halted                       : pipeline drained after halt
//   stall_cycles                 : saturating count of pc_en=0 cycles
//   hz_state                     : current FSM state (debug)
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_dMemREN,
  input  regbits_t         idex_writeReg,
  input  logic             exmem_dMemREN,
  input  logic             exmem_dMemWEN,
  input  logic             exmem_Halt,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             ifid_writeEN,
  output logic             ifid_flush,
  output logic             idex_writeEN,
  output logic             idex_flush,
  output logic             exmem_writeEN,
  output logic             exmem_flush,
  output logic             memwb_writeEN,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output hzst_t            hz_state
);

  hzst_t            state;
  hzst_t            state_next;
  logic [CNT_W-1:0] cnt;
  logic             load_use;
  logic             mem_wait;

  load_use_detect u_load_use_detect (
    .idex_dMemREN  (idex_dMemREN),
    .idex_writeReg (idex_writeReg),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .load_use      (load_use)
  );

  assign mem_wait     = (exmem_dMemREN || exmem_dMemWEN) && !dhit;
  assign stall_cycles = cnt;
  assign hz_state     = state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      // HALTED cycles are idle, not stalls, so they are not counted.
      if (!pc_en && (state != HALTED) && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state;
    pc_en         = 1'b1;
    ifid_writeEN  = 1'b1;
    ifid_flush    = 1'b0;
    idex_writeEN  = 1'b1;
    idex_flush    = 1'b0;
    exmem_writeEN = 1'b1;
    exmem_flush   = 1'b0;
    memwb_writeEN = 1'b1;
    halted        = 1'b0;

    unique case (state)
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          // Freeze everything; any redirect or load-use stays in its latch
          // and is resolved on the cycle dhit arrives.
          state_next    = MEM_WAIT;
          pc_en         = 1'b0;
          ifid_writeEN  = 1'b0;
          idex_writeEN  = 1'b0;
          exmem_writeEN = 1'b0;
          memwb_writeEN = 1'b0;
        end else begin
          state_next = RUN;
          if (exmem_Halt) begin
            state_next  = DRAIN;
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (ex_redirect) begin
            // Kill the two wrong-path instructions in IF/ID and ID/EX.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            // Hold ID, inject one bubble into EX. Holding IF/ID wins over a
            // fetch-wait flush, which would otherwise destroy the held
            // instruction.
            pc_en        = 1'b0;
            ifid_writeEN = 1'b0;
            idex_flush   = 1'b1;
          end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        state_next  = HALTED;
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      HALTED: begin
        pc_en         = 1'b0;
        ifid_writeEN  = 1'b0;
        idex_writeEN  = 1'b0;
        exmem_writeEN = 1'b0;
        memwb_writeEN = 1'b0;
        halted        = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    // Outputs are inactive for as long as reset is held.
    if (!nRST) begin
      pc_en         = 1'b0;
      ifid_writeEN  = 1'b0;
      ifid_flush    = 1'b0;
      idex_writeEN  = 1'b0;
      idex_flush    = 1'b0;
      exmem_writeEN = 1'b0;
      exmem_flush   = 1'b0;
      memwb_writeEN = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table-driven single-cycle vectors in RUN
// plus hand-written multi-cycle sequences (mem wait, halt drain, async reset,
// counter saturation). Two instances share the inputs: one with CNT_W=4 and
// one with the default width.
module tb_pipe_hazard_ctrl;
  import cpu_types_pkg::*;

  // Control vector order: {pc_en, ifid_we, ifid_fl, idex_we, idex_fl,
  //                        exmem_we, exmem_fl, memwb_we, halted}
  localparam logic [8:0] V_RUN   = 9'b1_10_10_10_1_0;
  localparam logic [8:0] V_REDIR = 9'b1_11_11_10_1_0;
  localparam logic [8:0] V_LU    = 9'b0_00_11_10_1_0;
  localparam logic [8:0] V_FW    = 9'b0_11_10_10_1_0;
  localparam logic [8:0] V_ZERO  = 9'b0_00_00_00_0_0;
  localparam logic [8:0] V_DRAIN = 9'b0_11_11_11_1_0;
  localparam logic [8:0] V_HALT  = 9'b0_00_00_00_0_1;

  logic     CLK, nRST;
  logic     ihit, dhit, ifid_uses_rt, idex_dMemREN;
  logic     exmem_dMemREN, exmem_dMemWEN, exmem_Halt, ex_redirect;
  regbits_t ifid_rs, ifid_rt, idex_writeReg;

  logic        pc_n, ifwe_n, iffl_n, idwe_n, idfl_n, exwe_n, exfl_n, mwwe_n, hlt_n;
  logic        pc_w, ifwe_w, iffl_w, idwe_w, idfl_w, exwe_w, exfl_w, mwwe_w, hlt_w;
  logic [3:0]  cnt_n;
  logic [15:0] cnt_w;
  hzst_t       st_n, st_w;
  logic [8:0]  ctrl_n, ctrl_w;

  assign ctrl_n = {pc_n, ifwe_n, iffl_n, idwe_n, idfl_n, exwe_n, exfl_n, mwwe_n, hlt_n};
  assign ctrl_w = {pc_w, ifwe_w, iffl_w, idwe_w, idfl_w, exwe_w, exfl_w, mwwe_w, hlt_w};

  pipe_hazard_ctrl #(.CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dMemREN(idex_dMemREN), .idex_writeReg(idex_writeReg),
    .exmem_dMemREN(exmem_dMemREN), .exmem_dMemWEN(exmem_dMemWEN),
    .exmem_Halt(exmem_Halt), .ex_redirect(ex_redirect),
    .pc_en(pc_n), .ifid_writeEN(ifwe_n), .ifid_flush(iffl_n),
    .idex_writeEN(idwe_n), .idex_flush(idfl_n),
    .exmem_writeEN(exwe_n), .exmem_flush(exfl_n),
    .memwb_writeEN(mwwe_n), .halted(hlt_n),
    .stall_cycles(cnt_n), .hz_state(st_n)
  );

  pipe_hazard_ctrl dut_w (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dMemREN(idex_dMemREN), .idex_writeReg(idex_writeReg),
    .exmem_dMemREN(exmem_dMemREN), .exmem_dMemWEN(exmem_dMemWEN),
    .exmem_Halt(exmem_Halt), .ex_redirect(ex_redirect),
    .pc_en(pc_w), .ifid_writeEN(ifwe_w), .ifid_flush(iffl_w),
    .idex_writeEN(idwe_w), .idex_flush(idfl_w),
    .exmem_writeEN(exwe_w), .exmem_flush(exfl_w),
    .memwb_writeEN(mwwe_w), .halted(hlt_w),
    .stall_cycles(cnt_w), .hz_state(st_w)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_cnt = 0;
  logic [8:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ihit = 1'b1; dhit = 1'b0; ifid_uses_rt = 1'b0; idex_dMemREN = 1'b0;
    exmem_dMemREN = 1'b0; exmem_dMemWEN = 1'b0; exmem_Halt = 1'b0; ex_redirect = 1'b0;
    ifid_rs = 5'd1; ifid_rt = 5'd2; idex_writeReg = 5'd9;
  endtask

  // Called at posedge+1 with inputs applied; checks at negedge, then
  // advances one edge and updates the counter model.
  task automatic step(input logic [8:0] req, input string name);
    logic [8:0] e;
    exp_q.push_back(req);
    @(negedge CLK);
    e = exp_q.pop_front();
    chk(name, 32'(ctrl_n), 32'(e));
    chk({name, "_w"}, 32'(ctrl_w), 32'(e));
    chk({name, "_cnt4"}, 32'(cnt_n), sat(exp_cnt, 15));
    chk({name, "_cnt16"}, 32'(cnt_w), sat(exp_cnt, 65535));
    @(posedge CLK);
    #1;
    if (!e[8] && !e[0]) exp_cnt++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic       ihit, dhit, uses_rt, id_ren, ex_ren, ex_wen, redir;
    regbits_t   rs, rt, wreg;
    logic [8:0] req;
  } vec_t;

  vec_t vt[12];

  initial begin
    //            name          ihit dhit urt idren exren exwen redir rs    rt    wreg  req
    vt[0]  = '{"idle",          1,   0,   0,  0,    0,    0,    0,    5'd1, 5'd2, 5'd9, V_RUN};
    vt[1]  = '{"lu_rs",         1,   0,   0,  1,    0,    0,    0,    5'd5, 5'd2, 5'd5, V_LU};
    vt[2]  = '{"lu_r0",         1,   0,   0,  1,    0,    0,    0,    5'd0, 5'd2, 5'd0, V_RUN};
    vt[3]  = '{"lu_rt",         1,   0,   1,  1,    0,    0,    0,    5'd3, 5'd7, 5'd7, V_LU};
    vt[4]  = '{"rt_unused",     1,   0,   0,  1,    0,    0,    0,    5'd3, 5'd7, 5'd7, V_RUN};
    vt[5]  = '{"no_load",       1,   0,   0,  0,    0,    0,    0,    5'd5, 5'd2, 5'd5, V_RUN};
    vt[6]  = '{"redir_over_lu", 1,   0,   0,  1,    0,    0,    1,    5'd5, 5'd2, 5'd5, V_REDIR};
    vt[7]  = '{"fetch_wait",    0,   0,   0,  0,    0,    0,    0,    5'd1, 5'd2, 5'd9, V_FW};
    vt[8]  = '{"lu_and_fw",     0,   0,   0,  1,    0,    0,    0,    5'd6, 5'd2, 5'd6, V_LU};
    vt[9]  = '{"redir_fw",      0,   0,   0,  0,    0,    0,    1,    5'd1, 5'd2, 5'd9, V_REDIR};
    vt[10] = '{"load_dhit",     1,   1,   0,  0,    1,    0,    0,    5'd1, 5'd2, 5'd9, V_RUN};
    vt[11] = '{"store_dhit_rd", 1,   1,   0,  0,    0,    1,    1,    5'd1, 5'd2, 5'd9, V_REDIR};
  end

  // ---------------- test sequence ----------------
  initial begin
    drive_idle();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ctrl", 32'(ctrl_n), 32'(V_ZERO));
    chk("reset_cnt", 32'(cnt_n), 32'd0);
    chk("reset_state", 32'(st_n), 32'(RUN));
    nRST = 1'b1;

    // Table vectors, each one cycle in RUN.
    for (int i = 0; i < 12; i++) begin
      ihit = vt[i].ihit; dhit = vt[i].dhit; ifid_uses_rt = vt[i].uses_rt;
      idex_dMemREN = vt[i].id_ren; exmem_dMemREN = vt[i].ex_ren;
      exmem_dMemWEN = vt[i].ex_wen; ex_redirect = vt[i].redir;
      ifid_rs = vt[i].rs; ifid_rt = vt[i].rt; idex_writeReg = vt[i].wreg;
      step(vt[i].req, vt[i].name);
    end

    // Mem wait with a redirect held pending for 3 cycles.
    drive_idle();
    exmem_dMemREN = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(V_ZERO, "mem_wait");
      chk("mem_wait_state", 32'(st_n), 32'(MEM_WAIT));
    end
    dhit = 1'b1;
    step(V_REDIR, "dhit_release");
    chk("dhit_state", 32'(st_n), 32'(RUN));

    // Halt: one cycle entering DRAIN, one DRAIN cycle, then HALTED.
    drive_idle();
    exmem_Halt = 1'b1;
    step(V_DRAIN, "halt_enter");
    chk("halt_state1", 32'(st_n), 32'(DRAIN));
    exmem_Halt = 1'b0;
    step(V_DRAIN, "drain");
    chk("halt_state2", 32'(st_n), 32'(HALTED));
    for (int i = 0; i < 3; i++) step(V_HALT, "halted");

    // Asynchronous reset out of HALTED, between edges.
    #2 nRST = 1'b0;
    #1;
    chk("arst_halt_state", 32'(st_n), 32'(RUN));
    chk("arst_halt_ctrl", 32'(ctrl_n), 32'(V_ZERO));
    chk("arst_halt_cnt", 32'(cnt_w), 32'd0);
    exp_cnt = 0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    step(V_RUN, "after_halt_reset");

    // Asynchronous reset out of MEM_WAIT.
    exmem_dMemWEN = 1'b1;
    step(V_ZERO, "mw_before_reset");
    chk("mw_state", 32'(st_n), 32'(MEM_WAIT));
    #2 nRST = 1'b0;
    #1;
    chk("arst_mw_state", 32'(st_n), 32'(RUN));
    chk("arst_mw_cnt", 32'(cnt_n), 32'd0);
    exp_cnt = 0;
    drive_idle();
    @(posedge CLK);
    #1 nRST = 1'b1;
    step(V_RUN, "after_mw_reset");

    // Counter saturation: 20 fetch-wait cycles.
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) step(V_FW, "sat_fw");
    @(negedge CLK);
    chk("sat_cnt4", 32'(cnt_n), 32'd15);
    chk("sat_cnt16", 32'(cnt_w), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It is the driving end of the pipeline-latch control protocol: it produces `writeEN`/`flush` for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and `pc_en` for the PC. It decides these from fetch and memory handshakes, the load-use relation between ID and EX, EX-resolved redirects and halt. A small FSM sequences memory waits and the halt drain, and a saturating counter records stall cycles for the perf/debug path.

## Interface
- `CNT_W`, 16, width of `stall_cycles`.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction fetch completes this cycle.
- `dhit`  in  1  data access completes this cycle.
- `ifid_rs`  in  regbits_t  rs field of the instruction in ID.
- `ifid_rt`  in  regbits_t  rt field of the instruction in ID.
- `ifid_uses_rt`  in  1  the ID instruction reads rt (R-type, store, beq/bne).
- `idex_dMemREN`  in  1  dMemREN_out of the ID/EX latch.
- `idex_writeReg`  in  regbits_t  writeReg_out of the ID/EX latch.
- `exmem_dMemREN`, `exmem_dMemWEN`  in  1 each  memory op held in the EX/MEM latch.
- `exmem_Halt`  in  1  Halt held in the EX/MEM latch.
- `ex_redirect`  in  1  taken branch or jump/jr resolved in EX this cycle.
- `pc_en`  out  1  PC update enable.
- `ifid_writeEN`, `ifid_flush`  out  1 each  IF/ID latch controls.
- `idex_writeEN`, `idex_flush`  out  1 each  ID/EX latch controls.
- `exmem_writeEN`, `exmem_flush`  out  1 each  EX/MEM latch controls.
- `memwb_writeEN`  out  1  MEM/WB latch enable.
- `halted`  out  1  pipeline fully drained after halt.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `pc_en`=0 (excluding HALTED).

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN.
- Default, in RUN with no hazard: all writeEN=1, all flush=0, pc_en=1.
- Conditions are evaluated in this priority order:
  1. **Mem wait** (`exmem_dMemREN|exmem_dMemWEN`, and `!dhit`): all writeEN=0 and pc_en=0. All lower conditions are ignored; a redirect or load-use is held frozen and re-evaluated on a later cycle. RUN goes to MEM_WAIT, and MEM_WAIT stays until `dhit`. The `dhit` cycle itself applies the lower-priority rules and returns to RUN.
  2. **Halt** (`exmem_Halt` in RUN): go to DRAIN. In this cycle and in DRAIN: pc_en=0, ifid_flush=idex_flush=exmem_flush=1 (their writeEN=1), memwb_writeEN=1. DRAIN lasts exactly one cycle, then goes to HALTED.
  3. **Redirect** (`ex_redirect`): pc_en=1, ifid_flush=1, idex_flush=1. This overrides load-use.
  4. **Load-use**: `idex_dMemREN`, `idex_writeReg`≠0, and (`idex_writeReg`==`ifid_rs`, or `ifid_uses_rt` and `idex_writeReg`==`ifid_rt`). Response: pc_en=0, ifid_writeEN=0, idex_flush=1 (bubble). EX/MEM and MEM/WB advance.
  5. **Fetch wait** (`!ihit`): pc_en=0, ifid_flush=1. Downstream latches advance.
- If load-use and fetch wait coincide, load-use outputs apply. ifid_writeEN=0 takes precedence over ifid_flush, so ifid_flush=0 in that cycle.
- HALTED: all writeEN=0, flush=0, pc_en=0, halted=1. It is left only by reset.
- `stall_cycles` increments on every edge where pc_en=0 and the state is not HALTED. It saturates at 2^CNT_W−1.

## Timing
- Control outputs are combinational from state plus inputs, with zero-cycle latency. State and counter update on the rising edge of `CLK`.
- While `nRST`=0, all outputs are held inactive: every writeEN=0, every flush=0, pc_en=0, halted=0, stall_cycles=0.
- The first edge after release starts in RUN with the counter at 0.
- Reset asserted mid-MEM_WAIT or mid-DRAIN returns to RUN immediately and asynchronously.
- The load-use bubble is exactly one cycle per load. The redirect penalty is two flushed instructions.
- From `exmem_Halt` to `halted`=1 takes 2 edges.

## Structure
- Add `hzst_t` (RUN, MEM_WAIT, DRAIN, HALTED) to cpu_types_pkg. regbits_t is already there.
- Put the load-use compare in sub-module `load_use_detect` (pure combinational), so it can be reused by the forwarding-unit bench.
- Everything else stays in one always_ff block plus one always_comb block.

## Test plan
- Reset with nRST=0, then release: all outputs 0. With ihit=1 and no hazards: pc_en=1, every writeEN=1, stall_cycles=0.
- Load-use: idex_dMemREN=1, idex_writeReg=5, ifid_rs=5 → exactly one cycle with pc_en=0, ifid_writeEN=0, idex_flush=1; stall_cycles=1. Repeating with idex_writeReg=0 → no stall.
- Mem wait: exmem_dMemREN=1 with dhit=0 for 3 cycles, ex_redirect=1 throughout → all enables 0 for 3 cycles. On the dhit cycle: ifid_flush=idex_flush=1, pc_en=1.
- Redirect and load-use together → redirect outputs only: pc_en=1, ifid_flush=1, idex_flush=1.
- exmem_Halt=1 → DRAIN flushes for 1 cycle, then halted=1 and every writeEN=0. Pulsing nRST returns to RUN with halted=0.
- Counter saturation with CNT_W=4 and 20 fetch-wait cycles → stall_cycles=15.
